regfile_seq_master: RTL

- Command-driven initiator that drives the write port and read port A of the 8x16 register file.
- Runs bulk FILL, DUMP and COPY operations over a contiguous register range, one register per cycle.
- DUMP streams register contents out over a valid/ready interface.
- Used for register-file init, debug readback and context copy. It sits between the test/debug controller and the register file.

---
 rtl/regfile_seq_master_if.sv | 42 ++++
 rtl/regfile_seq_master.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_seq_master_if.sv
// rtl/regfile_seq_master_if.sv - command, register-file and dump-stream signals of regfile_seq_master
interface regfile_seq_master_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W:0]   cmd_count;
  logic [DATA_W-1:0] cmd_data;

  logic              rf_write;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_count, cmd_data,
    input  rf_rd_data, out_ready,
    output cmd_ready, rf_write, rf_wr_addr, rf_wr_data, rf_rd_addr,
    output out_valid, out_data, out_addr, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_count, cmd_data,
    output rf_rd_data, out_ready,
    input  cmd_ready, rf_write, rf_wr_addr, rf_wr_data, rf_rd_addr,
    input  out_valid, out_data, out_addr, busy, done, err
  );
endinterface

// File: rtl/regfile_seq_master.sv
// rtl/regfile_seq_master.sv - FILL/DUMP/COPY sequencer driving the register file write port and read port A
// One register per cycle over a wrapping range; DUMP beats leave through a registered valid/ready stage.
module regfile_seq_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_seq_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, FILL, DUMP, COPY} stateT;

  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

  stateT             state, stateNext;
  logic [ADDR_W-1:0] dstBase, srcBase;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] fillData;
  logic [ADDR_W:0]   idx, idxNext, idxInc;
  logic [ADDR_W-1:0] heldWrAddr;
  logic [DATA_W-1:0] heldWrData;
  logic              outValidQ, outValidNext;
  logic [DATA_W-1:0] outDataQ, outDataNext;
  logic [ADDR_W-1:0] outAddrQ, outAddrNext;
  logic              doneQ, doneNext;
  logic              errQ, errNext;

  logic              cmdReady, accept, cmdIllegal;
  logic              writeEn, rfWrite, lastElem, allIssued, canIssue;
  logic [ADDR_W-1:0] offs, wrAddrCur, rdAddrCur, rdAddr;
  logic [DATA_W-1:0] wrDataCur;

  assign cmdReady   = (state == IDLE) && !reset;
  assign accept     = bus.cmd_valid && cmdReady;
  assign cmdIllegal = (bus.cmd_op == 2'd3) || (bus.cmd_count == '0) ||
                      (bus.cmd_count > MAX_COUNT);

  // idx is the element index for FILL/COPY and the issued count for DUMP
  assign offs      = idx[ADDR_W-1:0];
  assign idxInc    = idx + 1'b1;
  assign wrAddrCur = dstBase + offs;
  assign rdAddrCur = ((state == COPY) ? srcBase : dstBase) + offs;
  assign lastElem  = (idxInc == count);
  assign allIssued = (idx == count);
  assign canIssue  = (!outValidQ || bus.out_ready) && !allIssued;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext    = state;
    idxNext      = idx;
    outValidNext = outValidQ;
    outDataNext  = outDataQ;
    outAddrNext  = outAddrQ;
    doneNext     = 1'b0;
    errNext      = 1'b0;
    writeEn      = 1'b0;
    rdAddr       = '0;
    wrDataCur    = fillData;

    case (state)
      IDLE: begin
        if (accept) begin
          if (cmdIllegal) begin
            errNext = 1'b1;
          end else begin
            idxNext = '0;
            case (bus.cmd_op)
              2'd0:    stateNext = FILL;
              2'd1:    stateNext = DUMP;
              default: stateNext = COPY;
            endcase
          end
        end
      end
      FILL: begin
        writeEn = 1'b1;
        if (lastElem) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end else begin
          idxNext = idxInc;
        end
      end
      COPY: begin
        // read data passes straight to the write port; the file commits at posedge,
        // so an overlapping forward copy sees its own earlier writes
        writeEn   = 1'b1;
        rdAddr    = rdAddrCur;
        wrDataCur = bus.rf_rd_data;
        if (lastElem) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end else begin
          idxNext = idxInc;
        end
      end
      DUMP: begin
        rdAddr = rdAddrCur;
        if (canIssue) begin
          outDataNext  = bus.rf_rd_data;
          outAddrNext  = rdAddrCur;
          outValidNext = 1'b1;
          idxNext      = idxInc;
        end else if (outValidQ && bus.out_ready && allIssued) begin
          outValidNext = 1'b0;
          stateNext    = IDLE;
          doneNext     = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign rfWrite = writeEn && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      dstBase    <= '0;
      srcBase    <= '0;
      count      <= '0;
      fillData   <= '0;
      idx        <= '0;
      heldWrAddr <= '0;
      heldWrData <= '0;
      outValidQ  <= 1'b0;
      outDataQ   <= '0;
      outAddrQ   <= '0;
      doneQ      <= 1'b0;
      errQ       <= 1'b0;
    end else begin
      idx       <= idxNext;
      outValidQ <= outValidNext;
      outDataQ  <= outDataNext;
      outAddrQ  <= outAddrNext;
      doneQ     <= doneNext;
      errQ      <= errNext;
      if (accept) begin
        dstBase  <= bus.cmd_dst;
        srcBase  <= bus.cmd_src;
        count    <= bus.cmd_count;
        fillData <= bus.cmd_data;
      end
      if (rfWrite) begin
        heldWrAddr <= wrAddrCur;
        heldWrData <= wrDataCur;
      end
    end
  end

  assign bus.cmd_ready  = cmdReady;
  assign bus.rf_write   = rfWrite;
  assign bus.rf_wr_addr = rfWrite ? wrAddrCur : heldWrAddr;
  assign bus.rf_wr_data = rfWrite ? wrDataCur : heldWrData;
  assign bus.rf_rd_addr = reset ? '0 : rdAddr;
  assign bus.out_valid  = outValidQ;
  assign bus.out_data   = outDataQ;
  assign bus.out_addr   = outAddrQ;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = doneQ;
  assign bus.err        = errQ;

endmodule
